// File: rtl/i2c_devid_master.sv
// Single-byte I2C address-frame master: START, {DevAddr,RW} MSB first, ACK sample, STOP.
// Outputs are decoded from the registered state, quarter and prescaler; no clock stretching or arbitration.
module i2c_devid_master #(
   parameter int unsigned QUARTER_CLKS = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic [6:0] DevAddr,
   input  logic       RW,
   input  logic       SdaIn,
   output logic       SCL,
   output logic       SdaDriveLow,
   output logic       Busy,
   output logic       Done,
   output logic       Nack
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BIT,
      ST_ACK,
      ST_STOP,
      ST_DONE
   } state_t;

   localparam logic [15:0] PRESC_LAST = 16'(QUARTER_CLKS - 1);

   state_t      state_reg, state_next;
   logic [1:0]  quarter_reg, quarter_next;
   logic [15:0] presc_reg, presc_next;
   logic [2:0]  bit_idx_reg, bit_idx_next;
   logic [7:0]  frame_reg, frame_next;
   logic        nack_reg, nack_next;
   logic        quarter_end;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg   <= ST_IDLE;
         quarter_reg <= '0;
         presc_reg   <= '0;
         bit_idx_reg <= '0;
         frame_reg   <= '0;
         nack_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         quarter_reg <= quarter_next;
         presc_reg   <= presc_next;
         bit_idx_reg <= bit_idx_next;
         frame_reg   <= frame_next;
         nack_reg    <= nack_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      quarter_next = quarter_reg;
      bit_idx_next = bit_idx_reg;
      frame_next   = frame_reg;
      nack_next    = nack_reg;
      quarter_end  = (presc_reg == PRESC_LAST);
      presc_next   = quarter_end ? '0 : presc_reg + 16'd1;
      SCL          = 1'b1;
      SdaDriveLow  = 1'b0;
      Busy         = 1'b1;
      Done         = 1'b0;

      case (state_reg)
         // DONE behaves as IDLE for Start so frames can run back to back
         ST_IDLE, ST_DONE: begin
            Busy         = 1'b0;
            Done         = (state_reg == ST_DONE);
            presc_next   = '0;
            quarter_next = '0;
            state_next   = ST_IDLE;
            if (Start) begin
               state_next = ST_START;
               frame_next = {DevAddr, RW};
               nack_next  = 1'b0;
            end
         end

         ST_START: begin
            SCL         = (quarter_reg == 2'd0);
            SdaDriveLow = 1'b1;
            if (quarter_end) begin
               quarter_next = quarter_reg + 2'd1;
               if (quarter_reg == 2'd1) begin
                  quarter_next = '0;
                  bit_idx_next = 3'd7;
                  state_next   = ST_BIT;
               end
            end
         end

         ST_BIT: begin
            SCL         = quarter_reg[1];
            SdaDriveLow = ~frame_reg[bit_idx_reg];
            if (quarter_end) begin
               quarter_next = quarter_reg + 2'd1;
               if (quarter_reg == 2'd3) begin
                  bit_idx_next = bit_idx_reg - 3'd1;
                  if (bit_idx_reg == 3'd0) begin
                     state_next = ST_ACK;
                  end
               end
            end
         end

         ST_ACK: begin
            SCL = quarter_reg[1];
            // sample at the end of the first high quarter, mid SCL-high
            if (quarter_end && quarter_reg == 2'd2) begin
               nack_next = SdaIn;
            end
            if (quarter_end) begin
               quarter_next = quarter_reg + 2'd1;
               if (quarter_reg == 2'd3) begin
                  state_next = ST_STOP;
               end
            end
         end

         ST_STOP: begin
            SCL         = (quarter_reg != 2'd0);
            SdaDriveLow = (quarter_reg != 2'd2);
            if (quarter_end) begin
               quarter_next = quarter_reg + 2'd1;
               if (quarter_reg == 2'd2) begin
                  quarter_next = '0;
                  state_next   = ST_DONE;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign Nack = nack_reg;

endmodule

// File: tb/tb_i2c_devid_master.sv
// Self-checking bench for i2c_devid_master: one instance with 4-cycle quarters, one with 1-cycle quarters.
// A bus monitor captures each frame; scenario tasks compare it with expectations queued at stimulus time.
module tb_i2c_devid_master;

   logic       clk = 1'b0;
   logic       reset_r;
   logic       start_r [2];
   logic [6:0] addr_r  [2];
   logic       rw_r    [2];
   logic       resp_r  [2];
   logic       sdain_w [2];
   logic       scl_w   [2];
   logic       sdl_w   [2];
   logic       busy_w  [2];
   logic       done_w  [2];
   logic       nack_w  [2];

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   // frame record: {bits[8], nack, ack_sda, rises[8], starts[4], stops[4], latency[16]}
   logic [41:0] exp_q0[$], exp_q1[$], obs_q0[$], obs_q1[$];

   int         rises[2], starts[2], stops[2], illegal[2], accept_cyc[2], done_cnt[2];
   logic [7:0] cap[2];
   logic       ack_sda[2], cur_sda[2], prev_scl[2], prev_sda[2], prev_busy[2];

   always #5 clk = ~clk;

   assign sdain_w[0] = sdl_w[0] ? 1'b0 : resp_r[0];
   assign sdain_w[1] = sdl_w[1] ? 1'b0 : resp_r[1];

   i2c_devid_master #(.QUARTER_CLKS(4)) dut (
      .Clk(clk), .Reset(reset_r), .Start(start_r[0]), .DevAddr(addr_r[0]), .RW(rw_r[0]),
      .SdaIn(sdain_w[0]), .SCL(scl_w[0]), .SdaDriveLow(sdl_w[0]), .Busy(busy_w[0]),
      .Done(done_w[0]), .Nack(nack_w[0])
   );

   i2c_devid_master #(.QUARTER_CLKS(1)) dut_q1 (
      .Clk(clk), .Reset(reset_r), .Start(start_r[1]), .DevAddr(addr_r[1]), .RW(rw_r[1]),
      .SdaIn(sdain_w[1]), .SCL(scl_w[1]), .SdaDriveLow(sdl_w[1]), .Busy(busy_w[1]),
      .Done(done_w[1]), .Nack(nack_w[1])
   );

   function automatic logic [41:0] exp_vec(input logic [6:0] a, input logic r, input logic resp, input int q);
      return {a, r, resp, 1'b1, 8'd10, 4'd1, 4'd1, 16'(41 * q + 1)};
   endfunction

   function automatic string fmt(input logic [41:0] v);
      return $sformatf("bits=%h nack=%b ack_sda=%b rises=%0d starts=%0d stops=%0d latency=%0d",
                       v[41:34], v[33], v[32], v[31:24], v[23:20], v[19:16], v[15:0]);
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Bus monitor, sampled mid-low-phase of clk after the bench has driven inputs
   initial begin
      for (int d = 0; d < 2; d++) begin
         rises[d] = 0; starts[d] = 0; stops[d] = 0; illegal[d] = 0; accept_cyc[d] = 0;
         done_cnt[d] = 0; cap[d] = '0; ack_sda[d] = 1'b0;
         prev_scl[d] = 1'b1; prev_sda[d] = 1'b1; prev_busy[d] = 1'b0;
      end
      forever begin
         @(negedge clk);
         #2;
         for (int d = 0; d < 2; d++) begin
            cur_sda[d] = ~sdl_w[d];
            if (!reset_r) begin
               if (scl_w[d] && prev_scl[d] && cur_sda[d] != prev_sda[d]) begin
                  if (!cur_sda[d]) begin
                     if (prev_busy[d]) illegal[d]++;
                     else starts[d]++;
                  end else if (busy_w[d]) begin
                     stops[d]++;
                  end
               end
               if (busy_w[d] && scl_w[d] && !prev_scl[d]) begin
                  rises[d]++;
                  if (rises[d] <= 8) cap[d] = {cap[d][6:0], cur_sda[d]};
                  else if (rises[d] == 9) ack_sda[d] = cur_sda[d];
               end
               if (done_w[d]) begin
                  done_cnt[d]++;
                  if (d == 0)
                     obs_q0.push_back({cap[d], nack_w[d], ack_sda[d], 8'(rises[d]), 4'(starts[d]),
                                       4'(stops[d]), 16'(cyc - accept_cyc[d])});
                  else
                     obs_q1.push_back({cap[d], nack_w[d], ack_sda[d], 8'(rises[d]), 4'(starts[d]),
                                       4'(stops[d]), 16'(cyc - accept_cyc[d])});
               end
               if (start_r[d] && !busy_w[d]) begin
                  accept_cyc[d] = cyc;
                  rises[d] = 0; starts[d] = 0; stops[d] = 0; cap[d] = '0; ack_sda[d] = 1'b0;
               end
            end
            prev_scl[d]  = scl_w[d];
            prev_sda[d]  = cur_sda[d];
            prev_busy[d] = busy_w[d];
         end
      end
   end

   task automatic drive_frame(input int d, input logic [6:0] a, input logic r, input logic resp);
      @(negedge clk);
      addr_r[d] = a; rw_r[d] = r; resp_r[d] = resp; start_r[d] = 1'b1;
      if (d == 0) exp_q0.push_back(exp_vec(a, r, resp, 4));
      else exp_q1.push_back(exp_vec(a, r, resp, 1));
      @(negedge clk);
      start_r[d] = 1'b0;
   endtask

   task automatic pop_frame(input int d, output logic got, output logic [41:0] o, output logic [41:0] e);
      got = 1'b0; o = '0; e = '0;
      for (int i = 0; i < 400; i++) begin
         if ((d == 0 && obs_q0.size() != 0) || (d == 1 && obs_q1.size() != 0)) break;
         @(negedge clk);
      end
      if (d == 0) begin
         if (exp_q0.size() != 0) e = exp_q0.pop_front();
         if (obs_q0.size() != 0) begin o = obs_q0.pop_front(); got = 1'b1; end
      end else begin
         if (exp_q1.size() != 0) e = exp_q1.pop_front();
         if (obs_q1.size() != 0) begin o = obs_q1.pop_front(); got = 1'b1; end
      end
   endtask

   task automatic test_reset();
      reset_r = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         compared++;
         if ({scl_w[d], sdl_w[d], busy_w[d], done_w[d], nack_w[d]} !== 5'b10000) begin
            mismatched++;
            $display("FAIL reset_outputs[%0d]: got scl/sdl/busy/done/nack=%b required 10000", d,
                     {scl_w[d], sdl_w[d], busy_w[d], done_w[d], nack_w[d]});
         end
      end
      reset_r = 1'b0;
      repeat (2) @(negedge clk);
      $display("test_reset: outputs checked in reset");
   endtask

   task automatic test_write_ack();
      logic got; logic [41:0] o, e;
      drive_frame(0, 7'h50, 1'b0, 1'b0);
      pop_frame(0, got, o, e);
      compared++;
      if (!got || o !== e) begin
         mismatched++;
         $display("FAIL write_ack_frame: got %s, required %s", got ? fmt(o) : "no frame", fmt(e));
      end
      $display("write frame 0x50/W: %s", fmt(o));
      repeat (5) @(negedge clk);
      compared++;
      if (nack_w[0] !== 1'b0) begin
         mismatched++;
         $display("FAIL write_ack_nack_hold: got %b required 0", nack_w[0]);
      end
   endtask

   task automatic test_read_nack();
      logic got; logic [41:0] o, e;
      drive_frame(0, 7'h2A, 1'b1, 1'b1);
      pop_frame(0, got, o, e);
      compared++;
      if (!got || o !== e) begin
         mismatched++;
         $display("FAIL read_nack_frame: got %s, required %s", got ? fmt(o) : "no frame", fmt(e));
      end
      $display("read frame 0x2A/R: %s", fmt(o));
      repeat (20) @(negedge clk);
      compared++;
      if (nack_w[0] !== 1'b1) begin
         mismatched++;
         $display("FAIL nack_hold: got %b required 1", nack_w[0]);
      end
      @(negedge clk);
      addr_r[0] = 7'h0F; rw_r[0] = 1'b0; resp_r[0] = 1'b0; start_r[0] = 1'b1;
      exp_q0.push_back(exp_vec(7'h0F, 1'b0, 1'b0, 4));
      compared++;
      if (nack_w[0] !== 1'b1) begin
         mismatched++;
         $display("FAIL nack_before_accept: got %b required 1", nack_w[0]);
      end
      @(negedge clk);
      start_r[0] = 1'b0;
      compared++;
      if (nack_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
         mismatched++;
         $display("FAIL nack_cleared_on_start: got nack=%b busy=%b required nack=0 busy=1", nack_w[0], busy_w[0]);
      end
      pop_frame(0, got, o, e);
      compared++;
      if (!got || o !== e) begin
         mismatched++;
         $display("FAIL follow_frame: got %s, required %s", got ? fmt(o) : "no frame", fmt(e));
      end
      $display("follow frame 0x0F/W: %s", fmt(o));
   endtask

   task automatic test_start_ignored();
      logic got; logic [41:0] o, e;
      int dc;
      dc = done_cnt[0];
      @(negedge clk);
      addr_r[0] = 7'h11; rw_r[0] = 1'b0; resp_r[0] = 1'b0; start_r[0] = 1'b1;
      exp_q0.push_back(exp_vec(7'h11, 1'b0, 1'b0, 4));
      @(negedge clk);
      start_r[0] = 1'b0;
      repeat (19) @(negedge clk);
      addr_r[0] = 7'h7F; rw_r[0] = 1'b1; start_r[0] = 1'b1;
      @(negedge clk);
      start_r[0] = 1'b0;
      pop_frame(0, got, o, e);
      compared++;
      if (!got || o !== e) begin
         mismatched++;
         $display("FAIL ignored_start_frame: got %s, required %s", got ? fmt(o) : "no frame", fmt(e));
      end
      $display("frame 0x11/W with mid-frame Start: %s", fmt(o));
      repeat (200) @(negedge clk);
      compared++;
      if (done_cnt[0] - dc != 1 || busy_w[0] !== 1'b0) begin
         mismatched++;
         $display("FAIL single_done: got dones=%0d busy=%b required dones=1 busy=0", done_cnt[0] - dc, busy_w[0]);
      end
   endtask

   task automatic test_reset_mid();
      logic got; logic [41:0] o, e;
      int dc;
      dc = done_cnt[0];
      @(negedge clk);
      addr_r[0] = 7'h30; rw_r[0] = 1'b0; resp_r[0] = 1'b0; start_r[0] = 1'b1;
      @(negedge clk);
      start_r[0] = 1'b0;
      repeat (81) @(negedge clk);
      compared++;
      if (scl_w[0] !== 1'b1 || sdl_w[0] !== 1'b1 || busy_w[0] !== 1'b1) begin
         mismatched++;
         $display("FAIL bit3_high_phase: got scl=%b sdl=%b busy=%b required 1 1 1", scl_w[0], sdl_w[0], busy_w[0]);
      end
      reset_r = 1'b1; start_r[0] = 1'b1; addr_r[0] = 7'h7F;
      @(negedge clk);
      compared++;
      if ({scl_w[0], sdl_w[0], busy_w[0], done_w[0]} !== 4'b1000) begin
         mismatched++;
         $display("FAIL reset_abort: got scl/sdl/busy/done=%b required 1000", {scl_w[0], sdl_w[0], busy_w[0], done_w[0]});
      end
      reset_r = 1'b0; start_r[0] = 1'b0;
      repeat (200) @(negedge clk);
      compared++;
      if (done_cnt[0] != dc || busy_w[0] !== 1'b0) begin
         mismatched++;
         $display("FAIL no_done_after_abort: got dones=%0d busy=%b required 0 0", done_cnt[0] - dc, busy_w[0]);
      end
      drive_frame(0, 7'h4B, 1'b1, 1'b0);
      pop_frame(0, got, o, e);
      compared++;
      if (!got || o !== e) begin
         mismatched++;
         $display("FAIL post_reset_frame: got %s, required %s", got ? fmt(o) : "no frame", fmt(e));
      end
      $display("frame 0x4B/R after abort: %s", fmt(o));
   endtask

   task automatic test_back_to_back();
      logic got, seen; logic [41:0] o, e;
      int dcyc[3];
      @(negedge clk);
      addr_r[1] = 7'h3C; rw_r[1] = 1'b1; resp_r[1] = 1'b0;
      for (int k = 0; k < 3; k++) exp_q1.push_back(exp_vec(7'h3C, 1'b1, 1'b0, 1));
      start_r[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         seen = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_w[1]) begin seen = 1'b1; break; end
         end
         dcyc[k] = cyc;
         compared++;
         if (!seen) begin
            mismatched++;
            $display("FAIL b2b_done_%0d: got no Done within 100 cycles required Done", k);
         end
         if (k == 2) begin
            start_r[1] = 1'b0;
         end else begin
            @(negedge clk);
            compared++;
            if (busy_w[1] !== 1'b1) begin
               mismatched++;
               $display("FAIL b2b_busy_after_done_%0d: got %b required 1", k, busy_w[1]);
            end
         end
      end
      for (int k = 0; k < 2; k++) begin
         compared++;
         if (dcyc[k + 1] - dcyc[k] != 42) begin
            mismatched++;
            $display("FAIL b2b_period_%0d: got %0d required 42", k, dcyc[k + 1] - dcyc[k]);
         end
      end
      for (int k = 0; k < 3; k++) begin
         pop_frame(1, got, o, e);
         compared++;
         if (!got || o !== e) begin
            mismatched++;
            $display("FAIL b2b_frame_%0d: got %s, required %s", k, got ? fmt(o) : "no frame", fmt(e));
         end
         $display("b2b frame %0d 0x3C/R: %s", k, fmt(o));
      end
   endtask

   task automatic test_sda_rule();
      for (int d = 0; d < 2; d++) begin
         compared++;
         if (illegal[d] != 0) begin
            mismatched++;
            $display("FAIL sda_change_scl_high[%0d]: got %0d illegal edges required 0", d, illegal[d]);
         end
      end
      $display("sda rule: illegal edges %0d / %0d", illegal[0], illegal[1]);
   endtask

   initial begin
      reset_r = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start_r[d] = 1'b0; addr_r[d] = '0; rw_r[d] = 1'b0; resp_r[d] = 1'b0;
      end
      test_reset();
      test_write_ack();
      test_read_nack();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      test_sda_rule();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/i2c_devid_master.md
I2C_DEVID_MASTER -- requirements
Module: i2c_devid_master

Interface
REQ-001 SHALL have parameter QUARTER_CLKS, default 4, giving the Clk cycles per SCL quarter-period; legal range 1..65535.
REQ-002 SHALL have port Clk, input, 1 bit: the single system clock; all logic updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Start, input, 1 bit: request to send one address frame; sampled in IDLE only.
REQ-005 SHALL have port DevAddr, input, 7 bits: target device address, latched on an accepted Start.
REQ-006 SHALL have port RW, input, 1 bit: read/write bit (1 = read), latched on an accepted Start.
REQ-007 SHALL have port SdaIn, input, 1 bit: the sensed SDA line level.
REQ-008 SHALL have port SCL, output, 1 bit: the generated bus clock.
REQ-009 SHALL have port SdaDriveLow, output, 1 bit: 1 pulls SDA low; 0 releases it (open-drain).
REQ-010 SHALL have port Busy, output, 1 bit: a frame is in progress.
REQ-011 SHALL have port Done, output, 1 bit: a one-cycle pulse at frame completion.
REQ-012 SHALL have port Nack, output, 1 bit: the ACK slot of the last frame was sampled high.

Function
REQ-013 SHALL transmit the frame byte {DevAddr[6:0], RW}, MSB first, so the responder's received byte has RW at bit 0 position of the transmitted order (last bit before ACK).
REQ-014 SHALL implement states IDLE, START, BIT, ACK, STOP, DONE, with a quarter counter (0..3) and a Clk-cycle prescaler (0..QUARTER_CLKS-1).
REQ-015 IDLE: SCL=1, SdaDriveLow=0, Busy=0; Start=1 latches DevAddr/RW, clears Nack, moves to START, and Busy=1 from the next cycle.
REQ-016 START, 2 quarters: q0 SCL=1, SDA low; q1 SCL=0, SDA low; then go to BIT with bit index 7.
REQ-017 BIT, 4 quarters per bit: q0–q1 SCL=0 with SDA set to the current bit (drive low for 0, release for 1); q2–q3 SCL=1 with SDA held; after q3 decrement the index; after index 0 go to ACK.
REQ-018 ACK, 4 quarters: SDA released throughout; SCL as in BIT; SdaIn sampled in the last Clk cycle of q2; Nack = sampled value.
REQ-019 STOP, 3 quarters: q0 SCL=0, SDA low; q1 SCL=1, SDA low; q2 SCL=1, SDA released.
REQ-020 DONE: lasts exactly one cycle with Done=1, Busy=0, SCL=1, SDA released; Start is accepted in this cycle exactly as in IDLE; then go to IDLE.
REQ-021 Latency: Done SHALL assert exactly 41*QUARTER_CLKS+1 cycles after the cycle in which Start is accepted.
REQ-022 SHALL ignore Start while Busy=1; latched DevAddr/RW are unaffected.
REQ-023 SHALL NOT sense SCL (no clock stretching) and SHALL NOT detect arbitration loss; on NACK the frame still completes with STOP.
REQ-024 SDA SHALL change only while SCL=0, except the START and STOP edges.
REQ-025 Nack SHALL hold its value until the next accepted Start.

Reset
REQ-026 Reset=1 at a Clk edge SHALL force IDLE, SCL=1, SdaDriveLow=0, Busy=0, Done=0, Nack=0, and clear counters and latched data.
REQ-027 Reset mid-frame SHALL abort without generating STOP and without a Done pulse; Reset overrides a simultaneous Start.

Verification
REQ-028 DevAddr=7'h50, RW=0, SdaIn=0 in the ACK slot, QUARTER_CLKS=4 -> SDA at the 8 SCL rises = 1,0,1,0,0,0,0,0; Done at cycle 165 after Start; Nack=0.
REQ-029 DevAddr=7'h2A, RW=1, SdaIn=1 in the ACK slot -> bits 0,1,0,1,0,1,0,1; STOP generated; Done pulses; Nack=1 until the next Start.
REQ-030 Start pulsed at cycle 20 of an active frame with DevAddr changed -> frame bits unchanged; only one Done.
REQ-031 Reset asserted during BIT index 3 -> next cycle SCL=1, SdaDriveLow=0, Busy=0; no Done; a following Start yields a complete correct frame.
REQ-032 QUARTER_CLKS=1, Start held high continuously -> back-to-back frames; each Done followed by Busy=1 next cycle; period 42 cycles.
REQ-033 Checker on every cycle: SDA transitions with SCL=1 occur only at START q0 and STOP q2.
